reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 53 +++++
 rtl/reg_file_mp.sv | 85 ++++++++
 tb/tb_reg_file_mp.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and address-width helper for the multi-port register file.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, plus a raw busy lookup per read port.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  parameter int unsigned AW    = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic              flush,
  output logic [NRD-1:0]    rd_busy
);

  localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

  logic [NREGS-1:0] busy;

  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < LIMIT);
  endfunction

  // Bit 0 is only ever touched by reset, so it stays 0. Issue outranks
  // writeback so a new producer of the same register remains outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (iss_valid && iss_addr == AW'(r))
          busy[r] <= 1'b1;
        else if (we && wr_addr == AW'(r))
          busy[r] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (valid_addr(rd_addr[i*AW +: AW]))
        rd_busy[i] = busy[rd_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with r0 hardwired to zero, optional write-to-read
// forwarding, and a pending-write scoreboard for hazard detection.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NRD    = NRD_DEF,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr_pi,
  output logic [NRD*XLEN-1:0] rd_data_po,
  output logic [NRD-1:0]      rd_busy_po,
  output logic                hazard_po,
  input  logic                we_pi,
  input  logic [AW-1:0]       wr_addr_pi,
  input  logic [XLEN-1:0]     wr_data_pi,
  input  logic                iss_valid_pi,
  input  logic [AW-1:0]       iss_addr_pi,
  input  logic                flush_pi
);

  localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   raddr [NRD];
  logic [NRD-1:0]  sb_busy;
  logic            wr_ok;

  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < LIMIT);
  endfunction

  for (genvar g = 0; g < NRD; g++) begin : g_raddr
    assign raddr[g] = rd_addr_pi[g*AW +: AW];
  end

  assign wr_ok = we_pi && valid_addr(wr_addr_pi);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr_pi] <= wr_data_pi;
    end
  end

  rf_scoreboard #(
    .NREGS(NREGS),
    .NRD  (NRD),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr_pi),
    .iss_valid(iss_valid_pi),
    .iss_addr (iss_addr_pi),
    .we       (we_pi),
    .wr_addr  (wr_addr_pi),
    .flush    (flush_pi),
    .rd_busy  (sb_busy)
  );

  // A forwarded read is also a completed write, so its busy flag is masked.
  always_comb begin
    rd_data_po = '0;
    rd_busy_po = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (valid_addr(raddr[i])) begin
        if (BYPASS != 0 && we_pi && wr_addr_pi == raddr[i]) begin
          rd_data_po[i*XLEN +: XLEN] = wr_data_pi;
        end else begin
          rd_data_po[i*XLEN +: XLEN] = regs[raddr[i]];
          rd_busy_po[i]              = sb_busy[i];
        end
      end
    end
  end

  assign hazard_po = |rd_busy_po;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp; a BYPASS=0 instance shares all inputs with the default one.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        hazard, hazard_nb;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr_pi(rd_addr), .rd_data_po(rd_data),
    .rd_busy_po(rd_busy), .hazard_po(hazard), .we_pi(we), .wr_addr_pi(wr_addr),
    .wr_data_pi(wr_data), .iss_valid_pi(iss_valid), .iss_addr_pi(iss_addr),
    .flush_pi(flush)
  );

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr_pi(rd_addr), .rd_data_po(rd_data_nb),
    .rd_busy_po(rd_busy_nb), .hazard_po(hazard_nb), .we_pi(we), .wr_addr_pi(wr_addr),
    .wr_data_pi(wr_data), .iss_valid_pi(iss_valid), .iss_addr_pi(iss_addr),
    .flush_pi(flush)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [4:0] a0, a1;
    reset = 1'b0; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL reset_out data=%h busy=%b hazard=%b exp 0/00/0", rd_data, rd_busy, hazard);
    end
    // Writes and issues held across two edges while in reset must be ignored.
    we = 1'b1; wr_addr = 5'd8; wr_data = 32'h1111_1111; iss_valid = 1'b1; iss_addr = 5'd8;
    step; step;
    we = 1'b0; iss_valid = 1'b0;
    #2 reset = 1'b0;
    for (int a = 1; a <= 31; a++) begin
      a0 = 5'(a);
      a1 = 5'(32 - a);
      rd_addr = {a1, a0};
      #1;
      checks++;
      if (rd_data !== 64'd0) begin
        errors++;
        $display("FAIL reset_read addr=%0d/%0d data=%h exp 0", a0, a1, rd_data);
      end
      checks++;
      if (hazard !== 1'b0 || rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_busy addr=%0d/%0d busy=%b hazard=%b exp 00/0", a0, a1, rd_busy, hazard);
      end
    end
    step;
  endtask

  task automatic test_bypass;
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    rd_addr = {5'd5, 5'd0};
    #1;
    checks++;
    if (rd_data[63:32] !== 32'hDEAD_BEEF || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL bypass_same_cycle data=%h busy=%b exp deadbeef/00", rd_data[63:32], rd_busy);
    end
    checks++;
    if (rd_data_nb[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle data=%h exp 00000000", rd_data_nb[63:32]);
    end
    checks++;
    if (rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL bypass_port0_r0 data=%h exp 00000000", rd_data[31:0]);
    end
    step;
    we = 1'b0;
    #1;
    checks++;
    if (rd_data[63:32] !== 32'hDEAD_BEEF || rd_data_nb[63:32] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_next_cycle data=%h nb=%h exp deadbeef", rd_data[63:32], rd_data_nb[63:32]);
    end
    step;
  endtask

  task automatic test_r0;
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_data_nb !== 64'd0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL r0_same_cycle data=%h nb=%h busy=%b exp 0/0/00", rd_data, rd_data_nb, rd_busy);
    end
    step;
    we = 1'b0;
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_data_nb !== 64'd0 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL r0_after data=%h nb=%h hazard=%b exp 0/0/0", rd_data, rd_data_nb, hazard);
    end
    step;
  endtask

  task automatic test_scoreboard;
    iss_valid = 1'b1; iss_addr = 5'd7;
    step;
    iss_valid = 1'b0;
    rd_addr = {5'd0, 5'd7};
    #1;
    checks++;
    if (rd_busy !== 2'b01 || hazard !== 1'b1 || rd_busy_nb !== 2'b01) begin
      errors++;
      $display("FAIL issue_busy busy=%b hazard=%b nb=%b exp 01/1/01", rd_busy, hazard, rd_busy_nb);
    end
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0777; iss_valid = 1'b1; iss_addr = 5'd7;
    #1;
    checks++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h0000_0777) begin
      errors++;
      $display("FAIL wb_issue_masked busy=%b data=%h exp 00/00000777", rd_busy, rd_data[31:0]);
    end
    checks++;
    if (rd_busy_nb !== 2'b01 || hazard_nb !== 1'b1) begin
      errors++;
      $display("FAIL wb_issue_nb busy=%b hazard=%b exp 01/1", rd_busy_nb, hazard_nb);
    end
    step;
    we = 1'b0; iss_valid = 1'b0;
    #1;
    checks++;
    if (rd_busy !== 2'b01 || hazard !== 1'b1 || rd_data[31:0] !== 32'h0000_0777) begin
      errors++;
      $display("FAIL set_wins busy=%b hazard=%b data=%h exp 01/1/00000777", rd_busy, hazard, rd_data[31:0]);
    end
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0888;
    step;
    we = 1'b0;
    #1;
    checks++;
    if (rd_busy !== 2'b00 || hazard !== 1'b0 || rd_busy_nb !== 2'b00) begin
      errors++;
      $display("FAIL wb_clears busy=%b hazard=%b nb=%b exp 00/0/00", rd_busy, hazard, rd_busy_nb);
    end
    checks++;
    if (rd_data[31:0] !== 32'h0000_0888) begin
      errors++;
      $display("FAIL wb_data data=%h exp 00000888", rd_data[31:0]);
    end
    step;
  endtask

  task automatic test_flush;
    iss_valid = 1'b1;
    iss_addr = 5'd3; step;
    iss_addr = 5'd4; step;
    iss_addr = 5'd9; step;
    iss_valid = 1'b0;
    rd_addr = {5'd9, 5'd3};
    #1;
    checks++;
    if (rd_busy !== 2'b11 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush_3_9 busy=%b hazard=%b exp 11/1", rd_busy, hazard);
    end
    rd_addr = {5'd10, 5'd4};
    #1;
    checks++;
    if (rd_busy !== 2'b01) begin
      errors++;
      $display("FAIL pre_flush_4_10 busy=%b exp 01", rd_busy);
    end
    flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd10;
    we = 1'b1; wr_addr = 5'd12; wr_data = 32'hC0FF_EE12;
    step;
    flush = 1'b0; iss_valid = 1'b0; we = 1'b0;
    rd_addr = {5'd4, 5'd3};
    #1;
    checks++;
    if (rd_busy !== 2'b00 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL flush_3_4 busy=%b hazard=%b exp 00/0", rd_busy, hazard);
    end
    rd_addr = {5'd10, 5'd9};
    #1;
    checks++;
    if (rd_busy !== 2'b00 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL flush_9_10 busy=%b hazard=%b exp 00/0", rd_busy, hazard);
    end
    rd_addr = {5'd12, 5'd0};
    #1;
    checks++;
    if (rd_data[63:32] !== 32'hC0FF_EE12 || rd_data_nb[63:32] !== 32'hC0FF_EE12) begin
      errors++;
      $display("FAIL flush_write data=%h nb=%h exp c0ffee12", rd_data[63:32], rd_data_nb[63:32]);
    end
    step;
  endtask

  task automatic test_back_to_back;
    logic [31:0] prev, cur;
    prev = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      cur = 32'h1000_0000 + 32'(k);
      we = 1'b1; wr_addr = 5'(k); wr_data = cur;
      rd_addr = {5'(k), 5'(k - 1)};
      #1;
      checks++;
      if (rd_data[63:32] !== cur || rd_data_nb[63:32] !== 32'h0) begin
        errors++;
        $display("FAIL b2b_fwd k=%0d data=%h nb=%h exp %h/00000000", k, rd_data[63:32], rd_data_nb[63:32], cur);
      end
      checks++;
      if (rd_data[31:0] !== prev || rd_data_nb[31:0] !== prev) begin
        errors++;
        $display("FAIL b2b_prev k=%0d data=%h nb=%h exp %h", k, rd_data[31:0], rd_data_nb[31:0], prev);
      end
      step;
      prev = cur;
    end
    wr_addr = 5'd31; wr_data = 32'hFFFF_FFFF;
    step;
    we = 1'b0;
    rd_addr = {5'd31, 5'd4};
    #1;
    checks++;
    if (rd_data !== {32'hFFFF_FFFF, 32'h1000_0004}) begin
      errors++;
      $display("FAIL b2b_r31 data=%h exp ffffffff10000004", rd_data);
    end
    step;
  endtask

  task automatic test_async_reset;
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'hA5A5_A5A5;
    iss_valid = 1'b1; iss_addr = 5'd2;
    step;
    we = 1'b0; iss_valid = 1'b0;
    rd_addr = {5'd0, 5'd2};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hA5A5_A5A5 || rd_busy !== 2'b01 || hazard !== 1'b1) begin
      errors++;
      $display("FAIL pre_async data=%h busy=%b hazard=%b exp a5a5a5a5/01/1", rd_data[31:0], rd_busy, hazard);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL async_reset data=%h busy=%b hazard=%b exp 0/00/0", rd_data, rd_busy, hazard);
    end
    checks++;
    if (rd_data_nb !== 64'd0 || rd_busy_nb !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_nb data=%h busy=%b exp 0/00", rd_data_nb, rd_busy_nb);
    end
    #2 reset = 1'b0;
    we = 1'b1; wr_addr = 5'd6; wr_data = 32'h0000_0066;
    #1;
    checks++;
    if (rd_busy !== 2'b00 || rd_data_nb[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_residual busy=%b data=%h exp 00/00000000", rd_busy, rd_data_nb[31:0]);
    end
    step;
    we = 1'b0;
    rd_addr = {5'd6, 5'd2};
    #1;
    checks++;
    if (rd_data_nb[63:32] !== 32'h0000_0066 || rd_data[31:0] !== 32'h0 || hazard !== 1'b0) begin
      errors++;
      $display("FAIL first_edge data6=%h data2=%h hazard=%b exp 00000066/0/0", rd_data_nb[63:32], rd_data[31:0], hazard);
    end
    step;
  endtask

  initial begin
    test_reset;
    test_bypass;
    test_r0;
    test_scoreboard;
    test_flush;
    test_back_to_back;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
